// File: rtl/PS2_pkg.sv
// rtl/PS2_pkg.sv - shared PS2 state encoding, default timing constants and parity helper
package PS2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQUEST,
    S_SEND_BITS,
    S_WAIT_ACK,
    S_WAIT_RELEASE
  } ps2_tx_state_t;

  // 100 us of clock inhibit and a 20 ms abort window at 50 MHz
  localparam logic [12:0] DEFAULT_INHIBIT_COUNT = 13'd5000;
  localparam logic [19:0] DEFAULT_TIMEOUT_COUNT = 20'd1000000;

  // PS2 frames carry odd parity: the bit is 1 when the byte has an even count of ones
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/PS2_line_sync.sv
// rtl/PS2_line_sync.sv - two-flop synchronizers for both PS2 lines plus clock falling-edge detect
module PS2_line_sync (
  input  logic CLOCK_50_I,
  input  logic resetn,
  input  logic PS2_CLOCK_I,
  input  logic PS2_DATA_I,
  output logic clock_synced,
  output logic data_synced,
  output logic clock_fall
);

  logic clock_meta;
  logic data_meta;
  logic clock_prev;

  // Idle PS2 lines float high, so every stage resets to 1 to avoid a phantom edge
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      clock_meta   <= 1'b1;
      clock_synced <= 1'b1;
      clock_prev   <= 1'b1;
      data_meta    <= 1'b1;
      data_synced  <= 1'b1;
    end else begin
      clock_meta   <= PS2_CLOCK_I;
      clock_synced <= clock_meta;
      clock_prev   <= clock_synced;
      data_meta    <= PS2_DATA_I;
      data_synced  <= data_meta;
    end
  end

  assign clock_fall = clock_prev & ~clock_synced;

endmodule

// File: rtl/ps2_transmitter.sv
// rtl/ps2_transmitter.sv - host-to-device PS2 byte transmitter with inhibit, ack check and timeout
module ps2_transmitter
  import PS2_pkg::*;
#(
  parameter logic [12:0] INHIBIT_COUNT = DEFAULT_INHIBIT_COUNT,
  parameter logic [19:0] TIMEOUT_COUNT = DEFAULT_TIMEOUT_COUNT
) (
  input  logic       CLOCK_50_I,
  input  logic       resetn,
  input  logic       TX_start,
  input  logic [7:0] TX_data,
  output logic       TX_busy,
  output logic       TX_done,
  output logic       TX_error,
  input  logic       PS2_CLOCK_I,
  input  logic       PS2_DATA_I,
  output logic       PS2_clock_oe,
  output logic       PS2_data_oe
);

  ps2_tx_state_t state;
  logic [9:0]    shift_reg;
  logic [3:0]    bit_cnt;
  logic [12:0]   inhibit_cnt;
  logic [19:0]   timeout_cnt;
  logic          acked;
  logic          clock_synced;
  logic          data_synced;
  logic          clock_fall;
  logic          timed_out;

  PS2_line_sync u_line_sync (
    .CLOCK_50_I   (CLOCK_50_I),
    .resetn       (resetn),
    .PS2_CLOCK_I  (PS2_CLOCK_I),
    .PS2_DATA_I   (PS2_DATA_I),
    .clock_synced (clock_synced),
    .data_synced  (data_synced),
    .clock_fall   (clock_fall)
  );

  assign TX_busy   = (state != S_IDLE);
  assign timed_out = (state == S_SEND_BITS || state == S_WAIT_ACK || state == S_WAIT_RELEASE)
                     && (timeout_cnt == TIMEOUT_COUNT - 20'd1);

  // Frame sequencer: inhibit, request-to-send, shift bits on device clock, check ack, wait for idle bus
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      inhibit_cnt  <= '0;
      timeout_cnt  <= '0;
      acked        <= 1'b0;
      PS2_clock_oe <= 1'b0;
      PS2_data_oe  <= 1'b0;
      TX_done      <= 1'b0;
      TX_error     <= 1'b0;
    end else begin
      TX_done  <= 1'b0;
      TX_error <= 1'b0;
      if (timed_out) begin
        // Device stopped clocking: abandon the frame and free both lines
        PS2_clock_oe <= 1'b0;
        PS2_data_oe  <= 1'b0;
        TX_error     <= 1'b1;
        state        <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (TX_start) begin
              shift_reg    <= {1'b1, odd_parity(TX_data), TX_data};
              bit_cnt      <= '0;
              inhibit_cnt  <= '0;
              PS2_clock_oe <= 1'b1;
              state        <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            // Leave one cycle for S_REQUEST so the clock is held low exactly INHIBIT_COUNT cycles
            if (inhibit_cnt == INHIBIT_COUNT - 13'd2) begin
              PS2_data_oe <= 1'b1;
              state       <= S_REQUEST;
            end else begin
              inhibit_cnt <= inhibit_cnt + 13'd1;
            end
          end
          S_REQUEST: begin
            PS2_clock_oe <= 1'b0;
            timeout_cnt  <= '0;
            state        <= S_SEND_BITS;
          end
          S_SEND_BITS: begin
            timeout_cnt <= timeout_cnt + 20'd1;
            if (clock_fall) begin
              PS2_data_oe <= ~shift_reg[0];
              shift_reg   <= {1'b0, shift_reg[9:1]};
              bit_cnt     <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd9) begin
                state <= S_WAIT_ACK;
              end
            end
          end
          S_WAIT_ACK: begin
            timeout_cnt <= timeout_cnt + 20'd1;
            if (clock_fall) begin
              acked <= ~data_synced;
              state <= S_WAIT_RELEASE;
            end
          end
          S_WAIT_RELEASE: begin
            timeout_cnt <= timeout_cnt + 20'd1;
            if (clock_synced && data_synced) begin
              TX_done  <= acked;
              TX_error <= ~acked;
              state    <= S_IDLE;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_transmitter.sv
// tb/tb_ps2_transmitter.sv - self-checking bench for ps2_transmitter with a behavioural keyboard
module tb_ps2_transmitter;

  localparam logic [12:0] INH = 13'd20;
  localparam logic [19:0] TMO = 20'd2000;

  logic       CLOCK_50_I = 1'b0;
  logic       resetn = 1'b0;
  logic       TX_start = 1'b0;
  logic [7:0] TX_data = 8'h00;
  logic       TX_busy, TX_done, TX_error;
  logic       PS2_clock_oe, PS2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk, ps2_dat;

  assign ps2_clk = ~PS2_clock_oe & dev_clk;
  assign ps2_dat = ~PS2_data_oe & dev_data;

  ps2_transmitter #(.INHIBIT_COUNT(INH), .TIMEOUT_COUNT(TMO)) dut (
    .CLOCK_50_I   (CLOCK_50_I),
    .resetn       (resetn),
    .TX_start     (TX_start),
    .TX_data      (TX_data),
    .TX_busy      (TX_busy),
    .TX_done      (TX_done),
    .TX_error     (TX_error),
    .PS2_CLOCK_I  (ps2_clk),
    .PS2_DATA_I   (ps2_dat),
    .PS2_clock_oe (PS2_clock_oe),
    .PS2_data_oe  (PS2_data_oe)
  );

  always #10 CLOCK_50_I = ~CLOCK_50_I;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_hi = 0;
  int done_cyc = 0, err_cyc = 0, coe_rise_cyc = 0;
  logic busy_at_done = 1'b0;
  logic coe_prev = 1'b0;

  always @(posedge CLOCK_50_I) cyc++;

  always @(negedge CLOCK_50_I) begin
    if (TX_done) begin done_cnt++; done_cyc = cyc; busy_at_done = TX_busy; end
    if (TX_error) begin err_cnt++; err_cyc = cyc; end
    if (TX_done && TX_error) both_hi++;
    if (PS2_clock_oe && !coe_prev) coe_rise_cyc = cyc;
    coe_prev = PS2_clock_oe;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference frame as seen on the data line: start 0, data LSB first, odd parity, stop 1
  function automatic logic [10:0] model_bits(input logic [7:0] d);
    logic [10:0] b;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1 + i] = d[i];
    b[9] = ($countones(d) % 2 == 0);
    b[10] = 1'b1;
    return b;
  endfunction

  task automatic start_frame(input logic [7:0] d);
    @(negedge CLOCK_50_I);
    TX_data = d;
    TX_start = 1'b1;
    @(negedge CLOCK_50_I);
    TX_start = 1'b0;
    TX_data = 8'($urandom);
  endtask

  // Keyboard: waits for clock release, samples the line while clock is high, then pulls it low
  task automatic device_frame(input bit ack, input int n_edges, output logic [10:0] bits, output bit ok);
    ok = 1'b0;
    bits = '0;
    for (int w = 0; w < 200; w++) begin
      if (!PS2_clock_oe) begin ok = 1'b1; break; end
      @(negedge CLOCK_50_I);
    end
    if (!ok) return;
    repeat (5) @(negedge CLOCK_50_I);
    for (int i = 0; i < n_edges; i++) begin
      repeat (20) @(negedge CLOCK_50_I);
      bits[i] = ps2_dat;
      if (i == 10) dev_data = ~ack;
      repeat (2) @(negedge CLOCK_50_I);
      dev_clk = 1'b0;
      repeat (20) @(negedge CLOCK_50_I);
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_result(input int d0, input int e0, input string name);
    bit seen = 1'b0;
    for (int w = 0; w < 40; w++) begin
      if (done_cnt != d0 || err_cnt != e0) begin seen = 1'b1; break; end
      @(negedge CLOCK_50_I);
    end
    repeat (3) @(negedge CLOCK_50_I);
    check({name, "_result_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic run_vector(input logic [7:0] d, input bit ack, input string name);
    logic [10:0] bits;
    bit ok;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    start_frame(d);
    device_frame(ack, 11, bits, ok);
    check({name, "_clock_release"}, 32'(ok), 32'd1);
    wait_result(d0, e0, name);
    check({name, "_bits"}, 32'(bits), 32'(model_bits(d)));
    check({name, "_done"}, 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
    check({name, "_error"}, 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
    if (ack) check({name, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    check({name, "_lines_released"}, {30'd0, PS2_clock_oe, PS2_data_oe}, 32'd0);
    check({name, "_busy_after"}, 32'(TX_busy), 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [10:0] bits;
    bit ok;
    int d0, e0, c0, hi_cycles;
    bit data_first;

    vecs[0] = '{8'hED, 1'b1};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'hED, 1'b0};
    vecs[3] = '{8'h00, 1'b1};
    vecs[4] = '{8'hFF, 1'b1};
    for (int i = 5; i < 8; i++) vecs[i] = '{8'($urandom), 1'($urandom_range(0, 1))};

    repeat (3) @(negedge CLOCK_50_I);
    check("reset_outputs", {27'd0, TX_busy, TX_done, TX_error, PS2_clock_oe, PS2_data_oe}, 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge CLOCK_50_I);

    for (int i = 0; i < 8; i++) run_vector(vecs[i].data, vecs[i].ack, $sformatf("vec%0d", i));

    // Inhibit length and start-bit ordering
    d0 = done_cnt; e0 = err_cnt;
    start_frame(8'h5A);
    hi_cycles = 0;
    data_first = 1'b0;
    for (int w = 0; w < 100; w++) begin
      if (!PS2_clock_oe) break;
      hi_cycles++;
      if (PS2_data_oe) data_first = 1'b1;
      @(negedge CLOCK_50_I);
    end
    check("inhibit_cycles", 32'(hi_cycles), 32'(INH));
    check("data_before_clock_release", 32'(data_first), 32'd1);
    device_frame(1'b1, 11, bits, ok);
    wait_result(d0, e0, "inhibit_frame");
    check("inhibit_frame_bits", 32'(bits), 32'(model_bits(8'h5A)));

    // Silent device: abort after exactly TMO cycles from request
    d0 = done_cnt; e0 = err_cnt;
    start_frame(8'h33);
    c0 = -1;
    for (int w = 0; w < 200; w++) begin
      if (!PS2_clock_oe) begin c0 = cyc; break; end
      @(negedge CLOCK_50_I);
    end
    for (int w = 0; w < int'(TMO) + 50; w++) begin
      if (err_cnt != e0) break;
      @(negedge CLOCK_50_I);
    end
    check("timeout_error", 32'(err_cnt - e0), 32'd1);
    check("timeout_latency", 32'(err_cyc - c0), 32'(TMO));
    check("timeout_no_done", 32'(done_cnt - d0), 32'd0);
    check("timeout_lines", {30'd0, PS2_clock_oe, PS2_data_oe}, 32'd0);

    // Reset in the middle of a frame, then a clean frame
    d0 = done_cnt; e0 = err_cnt;
    start_frame(8'hC3);
    device_frame(1'b1, 5, bits, ok);
    #3 resetn = 1'b0;
    #1 check("midreset_lines", {29'd0, TX_busy, PS2_clock_oe, PS2_data_oe}, 32'd0);
    repeat (3) @(negedge CLOCK_50_I);
    resetn = 1'b1;
    repeat (50) @(negedge CLOCK_50_I);
    check("midreset_no_pulse", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);
    run_vector(8'hED, 1'b1, "after_reset");

    // Start held high: later TX_data ignored, next frame begins the cycle after done
    d0 = done_cnt; e0 = err_cnt;
    @(negedge CLOCK_50_I);
    TX_data = 8'hA5;
    TX_start = 1'b1;
    @(negedge CLOCK_50_I);
    TX_data = 8'h3C;
    device_frame(1'b1, 11, bits, ok);
    wait_result(d0, e0, "held1");
    check("held1_bits", 32'(bits), 32'(model_bits(8'hA5)));
    check("held_restart_cycle", 32'(coe_rise_cyc), 32'(done_cyc + 1));
    TX_start = 1'b0;
    d0 = done_cnt; e0 = err_cnt;
    device_frame(1'b1, 11, bits, ok);
    wait_result(d0, e0, "held2");
    check("held2_bits", 32'(bits), 32'(model_bits(8'h3C)));
    check("held2_done", 32'(done_cnt - d0), 32'd1);

    check("done_error_exclusive", 32'(both_hi), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
